// File: rtl/activ_pipe.sv
// activ_pipe: three-stage pipelined activation unit (pass / ReLU / PWL sigmoid / PWL tanh).
// Optional tanh datapath guarded by ACTIV_TANH_EN; without it, mode 3 behaves as pass.
module activ_pipe #(
    parameter int W         = 16,
    parameter int FRAC      = 8,
    parameter int SEGS      = 16,
    parameter int SEG_SHIFT = 7,
    localparam int AW       = $clog2(SEGS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_x,
    input  logic [1:0]    in_mode,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_z,
    input  logic          cfg_we,
    input  logic          cfg_sel,
    input  logic [AW-1:0] cfg_addr,
    input  logic [W-1:0]  cfg_data
);

    typedef enum logic [1:0] {
        MODE_PASS = 2'd0,
        MODE_RELU = 2'd1,
        MODE_SIG  = 2'd2,
        MODE_TANH = 2'd3
    } mode_e;

    localparam logic [W-1:0]  MAXP    = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0]  MINN    = {1'b1, {(W-1){1'b0}}};
    localparam logic [W-1:0]  ONE     = W'(1) << FRAC;
    localparam logic [W-1:0]  IDX_MAX = W'(SEGS - 1);

    // PWL tables: no reset, so contents survive a pipeline flush
    logic [W-1:0] slope_q [SEGS];
    logic [W-1:0] icpt_q  [SEGS];

    // Stage registers
    logic          s1_valid_q, s2_valid_q, s3_valid_q;
    mode_e         s1_mode_q,  s2_mode_q;
    logic          s1_neg_q,   s2_neg_q;
    logic [W-1:0]  s1_x_q,     s2_x_q;
    logic [W-1:0]  s1_xa_q;
    logic [W-1:0]  s1_slope_q;
    logic [W-1:0]  s1_icpt_q,  s2_icpt_q;
    logic [W-1:0]  s2_mx_q;
    logic [W-1:0]  s3_z_q;

    // Next-state values
    mode_e         s1_mode_d;
    logic          s1_neg_d;
    logic [W-1:0]  s1_abs_d;
    logic [W-1:0]  s1_xa_d;
    logic [AW-1:0] s1_idx_d;
    logic [W-1:0]  s2_mx_d;
    logic [W:0]    s3_sum_d;
    logic [W-1:0]  s3_y_d;
    logic [W-1:0]  s3_s_d;
    logic [W-1:0]  s3_z_d;

    // Stage can take a new entry
    logic s1_free, s2_free, s3_free;

    assign s3_free  = !s3_valid_q || out_ready;
    assign s2_free  = !s2_valid_q || s3_free;
    assign s1_free  = !s1_valid_q || s2_free;
    assign in_ready = s1_free && !rst;

    assign out_valid = s3_valid_q && !rst;
    assign out_z     = rst ? '0 : s3_z_q;

    // Table write port; S1 reads below see the pre-edge contents
    always_ff @(posedge clk) begin
        if (cfg_we) begin
            if (cfg_sel) begin
                icpt_q[cfg_addr] <= cfg_data;
            end else begin
                slope_q[cfg_addr] <= cfg_data;
            end
        end
    end

    // S1: magnitude, optional tanh doubling, segment select
    always_comb begin
        s1_mode_d = mode_e'(in_mode);
        s1_neg_d  = in_x[W-1];
        if (in_x == MINN) begin
            s1_abs_d = MAXP;
        end else if (s1_neg_d) begin
            s1_abs_d = '0 - in_x;
        end else begin
            s1_abs_d = in_x;
        end
        s1_xa_d = s1_abs_d;
`ifdef ACTIV_TANH_EN
        if (s1_mode_d == MODE_TANH) begin
            if (({1'b0, s1_abs_d} << 1) > {1'b0, MAXP}) begin
                s1_xa_d = MAXP;
            end else begin
                s1_xa_d = W'({1'b0, s1_abs_d} << 1);
            end
        end
`endif
        if ((s1_xa_d >> SEG_SHIFT) > IDX_MAX) begin
            s1_idx_d = AW'(SEGS - 1);
        end else begin
            s1_idx_d = AW'(s1_xa_d >> SEG_SHIFT);
        end
    end

    // S2: unsigned Q(FRAC) multiply, truncated to W bits
    always_comb begin
        s2_mx_d = W'(({{W{1'b0}}, s1_xa_q} * {{W{1'b0}}, s1_slope_q}) >> FRAC);
    end

    // S3: add intercept, saturate at ONE, mirror for negative inputs, map by mode
    always_comb begin
        s3_sum_d = {1'b0, s2_mx_q} + {1'b0, s2_icpt_q};
        s3_y_d   = (s3_sum_d > {1'b0, ONE}) ? ONE : W'(s3_sum_d);
        s3_s_d   = s2_neg_q ? (ONE - s3_y_d) : s3_y_d;
        case (s2_mode_q)
            MODE_SIG:  s3_z_d = s3_s_d;
`ifdef ACTIV_TANH_EN
            MODE_TANH: s3_z_d = W'(s3_s_d << 1) - ONE;
`endif
            MODE_RELU: s3_z_d = s2_neg_q ? '0 : s2_x_q;
            default:   s3_z_d = s2_x_q;
        endcase
    end

    // Valid bits and output register
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s3_valid_q <= 1'b0;
            s3_z_q     <= '0;
        end else begin
            if (s1_free) begin
                s1_valid_q <= in_valid;
            end
            if (s2_free) begin
                s2_valid_q <= s1_valid_q;
            end
            if (s3_free) begin
                s3_valid_q <= s2_valid_q;
                if (s2_valid_q) begin
                    s3_z_q <= s3_z_d;
                end
            end
        end
    end

    // Datapath registers load whenever their stage is free
    always_ff @(posedge clk) begin
        if (s1_free) begin
            s1_mode_q  <= s1_mode_d;
            s1_neg_q   <= s1_neg_d;
            s1_x_q     <= in_x;
            s1_xa_q    <= s1_xa_d;
            s1_slope_q <= slope_q[s1_idx_d];
            s1_icpt_q  <= icpt_q[s1_idx_d];
        end
        if (s2_free) begin
            s2_mode_q <= s1_mode_q;
            s2_neg_q  <= s1_neg_q;
            s2_x_q    <= s1_x_q;
            s2_mx_q   <= s2_mx_d;
            s2_icpt_q <= s1_icpt_q;
        end
    end

endmodule

// File: tb/tb_activ_pipe.sv
// Directed self-checking bench for activ_pipe (W=16, FRAC=8).
// Covers reset, ReLU, sigmoid, tanh/pass for mode 3, backpressure, table write hazard, mid-stream reset.
module tb_activ_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_x;
    logic [1:0]  in_mode;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_z;
    logic        cfg_we;
    logic        cfg_sel;
    logic [3:0]  cfg_addr;
    logic [15:0] cfg_data;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] bp [5];
    int          acc;

    activ_pipe #(
        .W(16),
        .FRAC(8),
        .SEGS(16),
        .SEG_SHIFT(7)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_x(in_x),
        .in_mode(in_mode),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_z(out_z),
        .cfg_we(cfg_we),
        .cfg_sel(cfg_sel),
        .cfg_addr(cfg_addr),
        .cfg_data(cfg_data)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cfg_write(input logic sel, input logic [3:0] addr, input logic [15:0] data);
        cfg_we   = 1'b1;
        cfg_sel  = sel;
        cfg_addr = addr;
        cfg_data = data;
        step();
        cfg_we   = 1'b0;
    endtask

    // One isolated sample: accepted this cycle, result expected exactly 3 cycles later
    task automatic run1(input string tag, input logic [15:0] x, input logic [1:0] m,
                        input logic [15:0] exp);
        in_valid = 1'b1;
        in_x     = x;
        in_mode  = m;
        #1;
        chk({tag, "_rdy"}, 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        #1;
        chk({tag, "_v1"}, 32'(out_valid), 32'd0);
        step();
        #1;
        chk({tag, "_v2"}, 32'(out_valid), 32'd0);
        step();
        #1;
        chk({tag, "_v3"}, 32'(out_valid), 32'd1);
        chk({tag, "_z"}, 32'(out_z), 32'(exp));
        step();
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_x      = '0;
        in_mode   = 2'd0;
        out_ready = 1'b1;
        cfg_we    = 1'b0;
        cfg_sel   = 1'b0;
        cfg_addr  = '0;
        cfg_data  = '0;
        bp[0] = 16'h0011; bp[1] = 16'h0022; bp[2] = 16'h0033; bp[3] = 16'h0044; bp[4] = 16'h0055;

        // Reset state
        step();
        step();
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_z", 32'(out_z), 32'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);

        // ReLU
        run1("relu_neg", 16'hFF00, 2'd1, 16'h0000);
        run1("relu_pos", 16'h0180, 2'd1, 16'h0180);

        // Table load
        cfg_write(1'b0, 4'd0,  16'h0040);
        cfg_write(1'b1, 4'd0,  16'h0080);
        cfg_write(1'b0, 4'd15, 16'h0000);
        cfg_write(1'b1, 4'd15, 16'h0100);

        // Sigmoid
        run1("sig_pos", 16'h0040, 2'd2, 16'h0090);
        run1("sig_neg", 16'hFFC0, 2'd2, 16'h0070);
        run1("sig_max", 16'h7FFF, 2'd2, 16'h0100);
        run1("sig_min", 16'h8000, 2'd2, 16'h0000);

        // Mode 3
`ifdef ACTIV_TANH_EN
        run1("tanh_small", 16'h0020, 2'd3, 16'h0020);
`else
        run1("m3_pass_small", 16'h0020, 2'd3, 16'h0020);
        run1("m3_pass_big", 16'h0300, 2'd3, 16'h0300);
`endif

        // Backpressure: only 3 samples fit while the output is stalled
        out_ready = 1'b0;
        acc = 0;
        for (int c = 0; c < 8; c++) begin
            in_valid = 1'b1;
            in_mode  = 2'd0;
            in_x     = bp[acc];
            #1;
            if (in_ready) acc++;
            step();
        end
        #1;
        chk("bp_accepted", 32'(acc), 32'd3);
        chk("bp_in_ready", 32'(in_ready), 32'd0);
        chk("bp_hold_valid", 32'(out_valid), 32'd1);
        chk("bp_hold_z", 32'(out_z), 32'(bp[0]));
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_valid = (acc < 5);
            if (acc < 5) in_x = bp[acc];
            #1;
            if (i == 0) chk("bp_full_in_ready", 32'(in_ready), 32'd1);
            chk("bp_drain_valid", 32'(out_valid), 32'd1);
            chk("bp_drain_z", 32'(out_z), 32'(bp[i]));
            if (in_valid && in_ready) acc++;
            step();
        end
        in_valid = 1'b0;
        #1;
        chk("bp_total", 32'(acc), 32'd5);
        chk("bp_empty", 32'(out_valid), 32'd0);

        // Table hazard: write lands on the same edge that S1 reads the entry
        cfg_we   = 1'b1;
        cfg_sel  = 1'b1;
        cfg_addr = 4'd0;
        cfg_data = 16'h00A0;
        in_valid = 1'b1;
        in_x     = 16'h0040;
        in_mode  = 2'd2;
        step();
        cfg_we   = 1'b0;
        in_valid = 1'b0;
        step();
        step();
        #1;
        chk("hz_old_valid", 32'(out_valid), 32'd1);
        chk("hz_old_z", 32'(out_z), 32'h0090);
        step();
        run1("hz_new", 16'h0040, 2'd2, 16'h00B0);

        // Reset with two samples in flight
        in_valid = 1'b1;
        in_mode  = 2'd0;
        in_x     = 16'h1111;
        step();
        in_x     = 16'h2222;
        step();
        in_valid = 1'b0;
        rst      = 1'b1;
        #1;
        chk("mrst_in_ready", 32'(in_ready), 32'd0);
        chk("mrst_out_valid", 32'(out_valid), 32'd0);
        step();
        rst = 1'b0;
        #1;
        chk("mrst_ready_after", 32'(in_ready), 32'd1);
        for (int k = 0; k < 4; k++) begin
            chk("mrst_no_valid", 32'(out_valid), 32'd0);
            step();
        end
        run1("mrst_tbl0", 16'h0040, 2'd2, 16'h00B0);
        run1("mrst_tbl15", 16'h7FFF, 2'd2, 16'h0100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Absolute time bound so the run always ends
    initial begin
        #20000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
